modulo_controle_rolhas: RTL and testbench
=========================================

Name: modulo_controle_rolhas

Overview:
- Cork-stock controller that sits directly upstream of the 7-bit cork register stage.
- Owns the running cork count for the bottling line.
- Serves seal requests from the sealing station with a timed actuator cycle, and performs incremental refills on operator request.
- Drives the register stage's data input and enable, so the register always mirrors the current stock.

Parameters:
- CAPACIDADE, 99: maximum corks in stock (must be ≤127).
- REPOSICAO, 25: corks added per refill operation.
- LIMIAR_BAIXO, 5: low-stock threshold.
- T_VEDA, 3: sealing actuator duration in clock cycles (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- vedar_req  in  1  level; bottle present at sealing station, cork requested.
- repor  in  1  one-cycle pulse; operator refill request.
- vedar_ack  out  1  one-cycle pulse; cork applied, stock decremented.
- falha  out  1  one-cycle pulse; seal requested with empty stock.
- repor_fim  out  1  one-cycle pulse; refill operation finished.
- ocupado  out  1  high in VEDANDO or REPONDO.
- estoque_out  out  7  current stock count; feeds register m_in.
- estoque_en  out  1  enable to register stage; high the cycle after any count change.
- sem_rolha  out  1  high when count == 0.
- estoque_baixo  out  1  high when count ≤ LIMIAR_BAIXO.

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, state=OCIOSO, timer=0, added=0, repor_pend=0.
  - vedar_ack=falha=repor_fim=estoque_en=0.
  - sem_rolha=1, estoque_baixo=1.
  - Reset mid-operation aborts the seal or refill with no ack and no partial decrement.
- estoque_out = count register, unsigned 7 bits.
- sem_rolha and estoque_baixo are combinational from count.
- estoque_en is registered: it is asserted the cycle after count changes, so the register captures the new value one edge later.
- OCIOSO:
  - If repor or repor_pend: go to REPONDO, added=0, clear repor_pend. Refill has priority over sealing on the same cycle.
  - Else if vedar_req and count>0: go to VEDANDO, timer=T_VEDA-1.
  - Else if vedar_req and count==0: pulse falha for 1 cycle and stay in OCIOSO. falha re-pulses every cycle while vedar_req is held and the stock is empty.
- VEDANDO:
  - Decrement timer each cycle.
  - On the cycle with timer==0: count<=count-1, vedar_ack pulse, return to OCIOSO.
  - Total latency from request accepted to vedar_ack is T_VEDA cycles.
  - vedar_req is ignored while in this state.
  - A repor pulse arriving here sets repor_pend.
  - The requester must drop vedar_req the cycle after vedar_ack; otherwise a new seal starts.
- REPONDO:
  - Each cycle, if added<REPOSICAO and count<CAPACIDADE: count+1, added+1.
  - When added==REPOSICAO or count==CAPACIDADE: pulse repor_fim and return to OCIOSO with no further increment.
  - Refill at full stock: enter REPONDO, then repor_fim on the next cycle with count unchanged.
  - Further repor pulses in this state are dropped.
  - vedar_req waits until the refill completes.
- Count never wraps: it saturates at 0 (guarded by the falha path) and at CAPACIDADE.
- ocupado is high exactly while the state is VEDANDO or REPONDO.

Test Plan:
- Reset then idle: count=0, sem_rolha=1, estoque_baixo=1, ocupado=0, all pulses 0; vedar_req=1 → falha pulses every cycle, count stays 0.
- repor pulse from count=0: count ramps 1..25 over 25 cycles; repor_fim follows; estoque_en follows each change by 1 cycle; estoque_baixo drops when count reaches 6.
- Three more repor pulses: count 25→50→75→99. The last refill stops at 99 with added=24 and repor_fim asserted.
- count=10, vedar_req held 1 cycle then released: vedar_ack exactly 3 cycles after acceptance; count=9; one estoque_en pulse.
- repor pulse during VEDANDO with count=6: seal completes (count=5, estoque_baixo=1), then REPONDO starts automatically from repor_pend; final count=30.
- rst asserted at count=40 mid-VEDANDO (timer=1): next cycle count=0, state OCIOSO, no vedar_ack emitted.

Source files
------------

// File: rtl/modulo_controle_rolhas.sv
// modulo_controle_rolhas: cork stock controller with timed sealing and incremental refill
module modulo_controle_rolhas #(
  parameter int CAPACIDADE   = 99,
  parameter int REPOSICAO    = 25,
  parameter int LIMIAR_BAIXO = 5,
  parameter int T_VEDA       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vedar_req,
  input  logic       repor,
  output logic       vedar_ack,
  output logic       falha,
  output logic       repor_fim,
  output logic       ocupado,
  output logic [6:0] estoque_out,
  output logic       estoque_en,
  output logic       sem_rolha,
  output logic       estoque_baixo
);
  localparam int TW = $clog2(T_VEDA + 1);
  typedef enum logic [1:0] {OCIOSO, VEDANDO, REPONDO} estado_t;
  estado_t estado;
  logic [6:0] count, count_d, added;
  logic [TW-1:0] timer;
  logic repor_pend;
  assign estoque_out   = count;
  assign ocupado       = estado != OCIOSO;
  assign sem_rolha     = count == '0;
  assign estoque_baixo = count <= 7'(LIMIAR_BAIXO);
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= OCIOSO;
      count      <= '0;
      count_d    <= '0;
      added      <= '0;
      timer      <= '0;
      repor_pend <= 1'b0;
      vedar_ack  <= 1'b0;
      falha      <= 1'b0;
      repor_fim  <= 1'b0;
      estoque_en <= 1'b0;
    end else begin
      vedar_ack  <= 1'b0;
      falha      <= 1'b0;
      repor_fim  <= 1'b0;
      count_d    <= count;
      // enable trails the count change by one cycle
      estoque_en <= count != count_d;
      case (estado)
        OCIOSO: begin
          if (repor || repor_pend) begin
            estado     <= REPONDO;
            added      <= '0;
            repor_pend <= 1'b0;
          end else if (vedar_req && count != '0) begin
            estado <= VEDANDO;
            timer  <= TW'(T_VEDA - 1);
          end else if (vedar_req) begin
            falha <= 1'b1;
          end
        end
        VEDANDO: begin
          if (repor) repor_pend <= 1'b1;
          if (timer == '0) begin
            count     <= count - 7'd1;
            vedar_ack <= 1'b1;
            estado    <= OCIOSO;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        REPONDO: begin
          if (added < 7'(REPOSICAO) && count < 7'(CAPACIDADE)) begin
            count <= count + 7'd1;
            added <= added + 7'd1;
          end else begin
            repor_fim <= 1'b1;
            estado    <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_modulo_controle_rolhas.sv
// tb_modulo_controle_rolhas: directed scenarios plus randomized run against a stock model
module tb_modulo_controle_rolhas;
  localparam int CAP = 99, REP = 25, LIM = 5, TV = 3;
  logic clk = 0, rst = 1, vedar_req = 0, repor = 0;
  logic vedar_ack, falha, repor_fim, ocupado, estoque_en, sem_rolha, estoque_baixo;
  logic [6:0] estoque_out;
  int checks = 0, errors = 0;
  int m_cnt, m_prev, m_seal, m_fill;
  bit m_pend, e_ack, e_falha, e_fim, e_en;

  modulo_controle_rolhas dut (
    .clk(clk), .rst(rst), .vedar_req(vedar_req), .repor(repor),
    .vedar_ack(vedar_ack), .falha(falha), .repor_fim(repor_fim), .ocupado(ocupado),
    .estoque_out(estoque_out), .estoque_en(estoque_en), .sem_rolha(sem_rolha),
    .estoque_baixo(estoque_baixo)
  );

  always #5 clk = ~clk;

  // model: a seal is a countdown to the ack, a refill is a precomputed number of increments
  task automatic model_step();
    if (rst) begin
      m_cnt = 0; m_prev = 0; m_seal = 0; m_fill = -1; m_pend = 0;
      e_ack = 0; e_falha = 0; e_fim = 0; e_en = 0;
    end else begin
      e_en = m_cnt != m_prev;
      m_prev = m_cnt;
      e_ack = 0; e_falha = 0; e_fim = 0;
      if (m_fill >= 0) begin
        if (m_fill > 0) begin m_cnt++; m_fill--; end
        else begin e_fim = 1; m_fill = -1; end
      end else if (m_seal > 0) begin
        if (repor) m_pend = 1;
        if (m_seal == 1) begin m_cnt--; e_ack = 1; end
        m_seal--;
      end else if (repor || m_pend) begin
        m_pend = 0;
        m_fill = (CAP - m_cnt < REP) ? CAP - m_cnt : REP;
      end else if (vedar_req) begin
        if (m_cnt > 0) m_seal = TV;
        else e_falha = 1;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic r);
    vedar_req = v;
    repor = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_seal(output int lat);
    cyc(1, 0);
    lat = 0;
    do begin cyc(0, 0); lat++; end while (!vedar_ack && lat < 10);
  endtask

  task automatic wait_fim(output int n);
    n = 0;
    do begin cyc(0, 0); n++; end while (!repor_fim && n < 40);
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(0, 0);
    cyc(0, 0);
    rst = 0;
    cyc(0, 0);
    checks++;
    if (estoque_out !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", estoque_out); end
    checks++;
    if ({sem_rolha, estoque_baixo, ocupado} !== 3'b110) begin
      errors++; $display("FAIL reset_flags got %b exp 110", {sem_rolha, estoque_baixo, ocupado});
    end
    checks++;
    if ({vedar_ack, falha, repor_fim, estoque_en} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000", {vedar_ack, falha, repor_fim, estoque_en});
    end
  endtask

  task automatic test_falha();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      checks++;
      if (falha !== 1'b1 || estoque_out !== 7'd0 || ocupado !== 1'b0) begin
        errors++; $display("FAIL falha_repeat cycle %0d got falha=%b count=%0d exp falha=1 count=0", i, falha, estoque_out);
      end
    end
    cyc(0, 0);
    checks++;
    if (falha !== 1'b0) begin errors++; $display("FAIL falha_release got %b exp 0", falha); end
  endtask

  task automatic test_refill_ramp();
    int bad;
    cyc(0, 1);
    checks++;
    if (ocupado !== 1'b1 || estoque_out !== 7'd0) begin
      errors++; $display("FAIL refill_enter got ocupado=%b count=%0d exp 1/0", ocupado, estoque_out);
    end
    bad = 0;
    for (int i = 1; i <= REP; i++) begin
      cyc(0, 0);
      if (estoque_out !== 7'(i) || estoque_en !== (i > 1) || estoque_baixo !== (i <= LIM) || repor_fim !== 1'b0) begin
        bad++;
        $display("FAIL refill_ramp step %0d got count=%0d en=%b baixo=%b exp count=%0d en=%b baixo=%b",
                 i, estoque_out, estoque_en, estoque_baixo, i, i > 1, i <= LIM);
      end
    end
    checks++;
    if (bad != 0) errors++;
    cyc(0, 0);
    checks++;
    if (repor_fim !== 1'b1 || estoque_out !== 7'd25 || estoque_en !== 1'b1) begin
      errors++; $display("FAIL refill_fim got fim=%b count=%0d en=%b exp 1/25/1", repor_fim, estoque_out, estoque_en);
    end
    cyc(0, 0);
    checks++;
    if (ocupado !== 1'b0 || estoque_en !== 1'b0) begin
      errors++; $display("FAIL refill_idle got ocupado=%b en=%b exp 0/0", ocupado, estoque_en);
    end
  endtask

  task automatic test_refill_full();
    int exp_cnt[3] = '{50, 75, 99};
    int n;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1);
      wait_fim(n);
      checks++;
      if (estoque_out !== 7'(exp_cnt[k]) || n != (k == 2 ? 25 : 26)) begin
        errors++; $display("FAIL refill_multi %0d got count=%0d cycles=%0d exp count=%0d cycles=%0d",
                           k, estoque_out, n, exp_cnt[k], k == 2 ? 25 : 26);
      end
    end
    cyc(0, 1);
    cyc(0, 0);
    checks++;
    if (repor_fim !== 1'b1 || estoque_out !== 7'd99) begin
      errors++; $display("FAIL refill_at_full got fim=%b count=%0d exp 1/99", repor_fim, estoque_out);
    end
  endtask

  task automatic test_seal_latency();
    int lat, ens, n;
    rst = 1;
    cyc(0, 0);
    rst = 0;
    cyc(0, 1);
    wait_fim(n);
    for (int i = 0; i < 15; i++) do_seal(lat);
    checks++;
    if (estoque_out !== 7'd10) begin errors++; $display("FAIL seal_setup got %0d exp 10", estoque_out); end
    cyc(1, 0);
    lat = 0;
    ens = 0;
    do begin cyc(0, 0); lat++; ens += int'(estoque_en); end while (!vedar_ack && lat < 10);
    cyc(0, 0); ens += int'(estoque_en);
    cyc(0, 0); ens += int'(estoque_en);
    checks++;
    if (lat != TV) begin errors++; $display("FAIL seal_latency got %0d exp %0d", lat, TV); end
    checks++;
    if (estoque_out !== 7'd9) begin errors++; $display("FAIL seal_count got %0d exp 9", estoque_out); end
    checks++;
    if (ens != 1) begin errors++; $display("FAIL seal_en_pulses got %0d exp 1", ens); end
  endtask

  task automatic test_repor_during_seal();
    int lat, n;
    for (int i = 0; i < 3; i++) do_seal(lat);
    checks++;
    if (estoque_out !== 7'd6 || estoque_baixo !== 1'b0) begin
      errors++; $display("FAIL pend_setup got count=%0d baixo=%b exp 6/0", estoque_out, estoque_baixo);
    end
    cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 0);
    checks++;
    if (vedar_ack !== 1'b1 || estoque_out !== 7'd5 || estoque_baixo !== 1'b1) begin
      errors++; $display("FAIL pend_seal got ack=%b count=%0d baixo=%b exp 1/5/1", vedar_ack, estoque_out, estoque_baixo);
    end
    cyc(0, 0);
    checks++;
    if (ocupado !== 1'b1) begin errors++; $display("FAIL pend_autostart got ocupado=%b exp 1", ocupado); end
    wait_fim(n);
    checks++;
    if (repor_fim !== 1'b1 || estoque_out !== 7'd30) begin
      errors++; $display("FAIL pend_refill got fim=%b count=%0d exp 1/30", repor_fim, estoque_out);
    end
  endtask

  task automatic test_reset_mid_seal();
    int lat, n;
    cyc(0, 1);
    wait_fim(n);
    for (int i = 0; i < 15; i++) do_seal(lat);
    checks++;
    if (estoque_out !== 7'd40) begin errors++; $display("FAIL abort_setup got %0d exp 40", estoque_out); end
    cyc(1, 0);
    cyc(0, 0);
    checks++;
    if (ocupado !== 1'b1 || vedar_ack !== 1'b0) begin
      errors++; $display("FAIL abort_midseal got ocupado=%b ack=%b exp 1/0", ocupado, vedar_ack);
    end
    rst = 1;
    cyc(0, 0);
    rst = 0;
    checks++;
    if (estoque_out !== 7'd0 || ocupado !== 1'b0 || vedar_ack !== 1'b0) begin
      errors++; $display("FAIL abort_reset got count=%0d ocupado=%b ack=%b exp 0/0/0", estoque_out, ocupado, vedar_ack);
    end
    cyc(0, 0);
    checks++;
    if (vedar_ack !== 1'b0 || estoque_en !== 1'b0 || estoque_out !== 7'd0) begin
      errors++; $display("FAIL abort_after got ack=%b en=%b count=%0d exp 0/0/0", vedar_ack, estoque_en, estoque_out);
    end
  endtask

  task automatic test_random();
    logic [13:0] got, exp;
    rst = 1;
    cyc(0, 0);
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      cyc(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 14) == 0));
      got = {estoque_out, vedar_ack, falha, repor_fim, ocupado, estoque_en, sem_rolha, estoque_baixo};
      exp = {7'(m_cnt), e_ack, e_falha, e_fim, m_seal > 0 || m_fill >= 0, e_en, m_cnt == 0, m_cnt <= LIM};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random cycle %0d got %b exp %b", i, got, exp);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_falha();
    test_refill_ramp();
    test_refill_full();
    test_seal_latency();
    test_repor_during_seal();
    test_reset_mid_seal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
